// File: rtl/hazard_fetch_if.sv
// Fetch-unit bus: program-load write port, redirect, control inputs and issue outputs.
// The master drives loads and control; the slave (fetch unit) returns the issued word.
interface hazard_fetch_if #(
  parameter int ADDR_W = 8
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [15:0]       wdata;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;
  logic              stall;
  logic              hz_en;
  logic [15:0]       inst_out;
  logic              inst_valid;
  logic              bubble;
  logic [ADDR_W-1:0] pc_out;

  modport master (
    output we, waddr, wdata, pc_load, pc_target, stall, hz_en,
    input  inst_out, inst_valid, bubble, pc_out
  );

  modport slave (
    input  we, waddr, wdata, pc_load, pc_target, stall, hz_en,
    output inst_out, inst_valid, bubble, pc_out
  );
endinterface

// File: rtl/hazard_fetch.sv
// Instruction fetch with RAW and branch bubble insertion; 1-cycle pc-to-issue latency.
// Stall freezes all fetch state (program writes still land); pc_load overrides stall.
module hazard_fetch #(
  parameter int ADDR_W   = 8,
  parameter int RAW_NOPS = 3,
  parameter int BR_NOPS  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_fetch_if.slave bus
);

  typedef enum logic {ST_FETCH, ST_BUBBLE} state_t;

  localparam int                DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [15:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_pc;
  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [2:0]        r_lw_rd;
  logic              r_lw_v;
  logic [15:0]       r_inst_out;
  logic              r_inst_valid;
  logic              r_bubble;

  logic [15:0] w_word;
  logic [2:0]  w_op;
  logic        w_wr_v;
  logic [2:0]  w_wr_rd;
  logic        w_rd_a_v;
  logic [2:0]  w_rd_a;
  logic        w_rd_b_v;
  logic [2:0]  w_rd_b;
  logic        w_is_br;
  logic        w_raw;

  // Writes land even under stall; a fetch of the same address this cycle sees the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n && bus.we) begin
      r_mem[bus.waddr] <= bus.wdata;
    end
  end

  always_comb begin
    w_word   = r_mem[r_pc];
    w_op     = w_word[15:13];
    w_wr_v   = 1'b0;
    w_wr_rd  = 3'd0;
    w_rd_a_v = 1'b0;
    w_rd_a   = 3'd0;
    w_rd_b_v = 1'b0;
    w_rd_b   = 3'd0;
    w_is_br  = 1'b0;
    if (w_word != 16'h0000) begin
      case (w_op)
        3'b000: begin
          w_wr_v   = 1'b1;
          w_wr_rd  = w_word[8:6];
          w_rd_a_v = 1'b1;
          w_rd_a   = w_word[2:0];
          w_rd_b_v = 1'b1;
          w_rd_b   = w_word[5:3];
        end
        3'b001, 3'b010: begin
          w_wr_v   = 1'b1;
          w_wr_rd  = w_word[2:0];
          w_rd_a_v = 1'b1;
          w_rd_a   = w_word[5:3];
        end
        3'b100:  w_is_br = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_raw = 1'b0;
    if (bus.hz_en && r_lw_v && (RAW_NOPS > 0)) begin
      w_raw = (w_rd_a_v && (w_rd_a == r_lw_rd)) || (w_rd_b_v && (w_rd_b == r_lw_rd));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= '0;
      r_state      <= ST_FETCH;
      r_cnt        <= 4'd0;
      r_lw_rd      <= 3'd0;
      r_lw_v       <= 1'b0;
      r_inst_out   <= 16'h0000;
      r_inst_valid <= 1'b0;
      r_bubble     <= 1'b0;
    end else if (bus.pc_load) begin
      r_pc         <= bus.pc_target;
      r_state      <= ST_FETCH;
      r_cnt        <= 4'd0;
      r_lw_v       <= 1'b0;
      r_inst_out   <= 16'h0000;
      r_inst_valid <= 1'b0;
      r_bubble     <= 1'b1;
    end else if (!bus.stall) begin
      case (r_state)
        ST_FETCH: begin
          r_inst_valid <= 1'b1;
          if (w_raw) begin
            // The hazard cycle is itself the first bubble, so BUBBLE covers the rest.
            r_inst_out <= 16'h0000;
            r_bubble   <= 1'b1;
            r_lw_v     <= 1'b0;
            if (RAW_NOPS > 1) begin
              r_cnt   <= 4'(RAW_NOPS - 1);
              r_state <= ST_BUBBLE;
            end else begin
              r_cnt   <= 4'd0;
            end
          end else begin
            r_inst_out <= w_word;
            r_bubble   <= 1'b0;
            r_pc       <= r_pc + PC_ONE;
            r_lw_v     <= w_wr_v;
            if (w_wr_v) begin
              r_lw_rd <= w_wr_rd;
            end
            if (w_is_br && bus.hz_en && (BR_NOPS > 0)) begin
              r_cnt   <= 4'(BR_NOPS);
              r_state <= ST_BUBBLE;
            end
          end
        end
        ST_BUBBLE: begin
          r_inst_out   <= 16'h0000;
          r_bubble     <= 1'b1;
          r_inst_valid <= 1'b1;
          if (r_cnt <= 4'd1) begin
            r_cnt   <= 4'd0;
            r_state <= ST_FETCH;
          end else begin
            r_cnt   <= r_cnt - 4'd1;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign bus.inst_out   = r_inst_out;
  assign bus.inst_valid = r_inst_valid;
  assign bus.bubble     = r_bubble;
  assign bus.pc_out     = r_pc;

endmodule

// File: doc/hazard_fetch.md
HAZARD_FETCH -- requirements
Module: hazard_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the program-memory address width; depth is 2**ADDR_W words of 16 bits.
REQ-002 SHALL have parameter RAW_NOPS, default 3, meaning the bubbles inserted for a read-after-write hazard (range 0..15).
REQ-003 SHALL have parameter BR_NOPS, default 2, meaning the bubbles inserted after a branch (range 0..15).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have ports we (input, 1), waddr (input, ADDR_W) and wdata (input, 16): the program-load write port.
REQ-007 SHALL have ports pc_load (input, 1) and pc_target (input, ADDR_W): the fetch-pointer redirect.
REQ-008 SHALL have ports stall (input, 1), freezing all fetch state, and hz_en (input, 1), enabling bubble insertion.
REQ-009 SHALL have outputs inst_out (16), inst_valid (1), bubble (1) and pc_out (ADDR_W, the current fetch pointer).

Function
REQ-010 SHALL decode opcode = word[15:13].
- 000: writes rd = [8:6]; reads [2:0] and [5:3].
- 001 or 010: writes rd = [2:0]; reads [5:3].
- 100: branch; writes nothing, reads nothing.
- Any other opcode, or a word equal to 0x0000: writes nothing, reads nothing.
REQ-011 SHALL perform the write mem[waddr] <= wdata on the edge when we=1, independent of stall; a same-cycle fetch of waddr SHALL see the old data.
REQ-012 SHALL read mem[pc] combinationally and register every output; issue latency is 1 cycle from pc to inst_out.
REQ-013 SHALL hold a last-writer register lw_rd (3 bits) with valid flag lw_v, tracking the last issued non-bubble writer.
REQ-014 SHALL implement the FSM states FETCH and BUBBLE, plus a 4-bit bubble counter cnt.
REQ-015 In FETCH with stall=0, a RAW hazard exists when hz_en=1, lw_v=1, RAW_NOPS>0 and any register read by mem[pc] equals lw_rd.
REQ-016 On a RAW hazard SHALL:
- output inst_out=0x0000, bubble=1 and inst_valid=1;
- leave pc unchanged and clear lw_v;
- set cnt=RAW_NOPS-1 and enter BUBBLE, or stay in FETCH if cnt would be 0.
REQ-017 With no RAW hazard in FETCH SHALL:
- output inst_out=mem[pc], bubble=0, inst_valid=1, and set pc<=pc+1;
- update lw_rd/lw_v from the issued word (lw_v=0 if it writes nothing).
REQ-018 If the issued word is a branch, and hz_en=1 and BR_NOPS>0, SHALL set cnt=BR_NOPS and enter BUBBLE.
REQ-019 In BUBBLE with stall=0 SHALL output 0x0000 with bubble=1 and decrement cnt; it SHALL return to FETCH on the edge where cnt reaches 0.
REQ-020 SHALL add the bubbles for one hazard back-to-back; RAW_NOPS bubbles total precede the dependent word, and BR_NOPS bubbles follow the branch.
REQ-021 SHALL wrap pc from 2**ADDR_W-1 to 0 without any flag.
REQ-022 With stall=1 SHALL hold pc, state, cnt, lw_rd/lw_v, inst_out, bubble and inst_valid.
REQ-023 pc_load=1 SHALL override stall and any state on that edge:
- pc<=pc_target, state<=FETCH, cnt<=0, lw_v<=0;
- inst_out<=0x0000, bubble<=1, inst_valid<=0.
REQ-024 With hz_en=0 SHALL issue sequentially with no bubbles; a BUBBLE already in progress SHALL complete.

Reset
REQ-025 When rst_n=0 SHALL asynchronously set pc=0, state=FETCH, cnt=0, lw_v=0, lw_rd=0, inst_out=0x0000, inst_valid=0 and bubble=0.
REQ-026 Memory contents SHALL NOT be altered by reset; writes SHALL be ignored while rst_n=0.
REQ-027 The first fetch SHALL occur on the first rising edge after rst_n is released.

Verification
REQ-028 RAW: with mem[0]=0x0040 and mem[1]=0x0001 (defaults) -> the bench sees 0x0040, three 0x0000 words with bubble=1, then 0x0001 with pc_out=2 after issue.
REQ-029 Branch: with mem[0]=0x8000 and mem[1]=0x2009 -> the bench sees 0x8000, two bubbles, then 0x2009, with no RAW bubble.
REQ-030 hz_en=0: with the REQ-028 program -> the bench sees 0x0040 then 0x0001 on consecutive cycles.
REQ-031 Stall: stall=1 for 2 cycles during the second RAW bubble -> outputs are frozen, and exactly 3 bubbles in total are still issued.
REQ-032 Redirect/wrap: pc_load=1 with pc_target=0xFF mid-BUBBLE -> inst_valid=0 and pc_out=0xFF; the next issue is mem[0xFF], after which pc_out=0x00.
REQ-033 Reset: rst_n driven low in BUBBLE, mid-cycle -> all outputs are zero immediately; after release, mem[0] issues on the first edge and memory is intact.
